// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then
// shifts a byte/parity/stop frame out on device clock falls and checks the ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 3000,
    parameter int SETUP_CYCLES   = 25,
    parameter int FILTER_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 375000
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic       wr,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe
);
    localparam int CMAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int FW   = $clog2(FILTER_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, SETUP, SHIFT, ACK, WAIT_IDLE} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [9:0]      shift, shift_n;
    logic [3:0]      bit_cnt, bit_n;
    logic            c_oe_n, d_oe_n, busy_n, done_n, err_n;
    logic            c_s1, c_s2, d_s1, d_s2;
    logic            c_filt;
    logic [FW-1:0]   fcnt;
    logic            fall, to_hit, abort;

    // Synchronisers plus a stability filter on the clock line; the bus idles high.
    always_ff @(posedge clk25) begin
        if (rst) begin
            c_s1   <= 1'b1;
            c_s2   <= 1'b1;
            d_s1   <= 1'b1;
            d_s2   <= 1'b1;
            c_filt <= 1'b1;
            fcnt   <= '0;
        end else begin
            c_s1 <= ps2c_in;
            c_s2 <= c_s1;
            d_s1 <= ps2d_in;
            d_s2 <= d_s1;
            if (c_s2 == c_filt) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILTER_CYCLES - 1)) begin
                c_filt <= c_s2;
                fcnt   <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    assign fall   = c_filt & ~c_s2 & (fcnt == FW'(FILTER_CYCLES - 1));
    assign to_hit = (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk25) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            shift   <= '0;
            bit_cnt <= '0;
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            shift   <= shift_n;
            bit_cnt <= bit_n;
            ps2c_oe <= c_oe_n;
            ps2d_oe <= d_oe_n;
            busy    <= busy_n;
            done    <= done_n;
            err     <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shift_n = shift;
        bit_n   = bit_cnt;
        c_oe_n  = ps2c_oe;
        d_oe_n  = ps2d_oe;
        busy_n  = busy;
        done_n  = 1'b0;
        err_n   = 1'b0;
        abort   = 1'b0;
        case (state)
            IDLE: begin
                c_oe_n = 1'b0;
                d_oe_n = 1'b0;
                if (wr) begin
                    shift_n = {1'b1, ~^data, data};
                    busy_n  = 1'b1;
                    c_oe_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
                    d_oe_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = SETUP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SETUP: begin
                if (cnt == CW'(SETUP_CYCLES - 1)) begin
                    c_oe_n  = 1'b0;
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = SHIFT;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SHIFT: begin
                if (fall) begin
                    d_oe_n  = ~shift[0];
                    shift_n = {1'b0, shift[9:1]};
                    bit_n   = bit_cnt + 1'b1;
                    cnt_n   = '0;
                    if (bit_cnt == 4'd9) state_n = ACK;
                end else if (to_hit) begin
                    abort = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ACK: begin
                if (fall) begin
                    if (!d_s2) begin
                        cnt_n   = '0;
                        state_n = WAIT_IDLE;
                    end else begin
                        abort = 1'b1;
                    end
                end else if (to_hit) begin
                    abort = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (c_filt && d_s2) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (to_hit) begin
                    abort = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // Timeout or NACK: release both lines and go back to IDLE with one err pulse.
        if (abort) begin
            err_n   = 1'b1;
            c_oe_n  = 1'b0;
            d_oe_n  = 1'b0;
            busy_n  = 1'b0;
            cnt_n   = '0;
            state_n = IDLE;
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the
// host and reports the received bits; timeout is shortened to keep runs short.
module tb_ps2_host_tx;
    localparam int INH = 3000;
    localparam int SET = 25;
    localparam int FLT = 64;
    localparam int TO  = 6000;
    localparam int HP  = 200;

    logic       clk25 = 1'b0;
    logic       rst, wr;
    logic [7:0] data;
    logic       busy, done, err, ps2c_oe, ps2d_oe;
    logic       dev_c = 1'b1;
    logic       dev_d = 1'b1;
    logic       pin_c, pin_d;

    assign pin_c = ~ps2c_oe & dev_c;
    assign pin_d = ~ps2d_oe & dev_d;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH), .SETUP_CYCLES(SET),
        .FILTER_CYCLES(FLT), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk25(clk25), .rst(rst), .wr(wr), .data(data),
        .busy(busy), .done(done), .err(err),
        .ps2c_in(pin_c), .ps2d_in(pin_d),
        .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe)
    );

    always #20 clk25 = ~clk25;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int err_seen = 0;
    int both_seen = 0;

    always @(negedge clk25) begin
        if (done) done_seen++;
        if (err) err_seen++;
        if (done && err) both_seen++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk25);
    endtask

    task automatic run_frame(input logic [7:0] d, input bit ack, input bit glitch,
                             input bit wr_mid, output logic [9:0] bits,
                             output int inh_n, output int set_n,
                             output int dn, output int er);
        int d0, e0, guard;
        d0 = done_seen;
        e0 = err_seen;
        bits = '0;
        inh_n = 0;
        set_n = 0;
        @(negedge clk25);
        wr = 1'b1;
        data = d;
        @(negedge clk25);
        wr = 1'b0;
        data = 8'h00;
        chk("busy_after_wr", int'(busy), 1);
        guard = 0;
        while (ps2c_oe && guard < 5000) begin
            if (ps2d_oe) set_n++;
            else inh_n++;
            @(negedge clk25);
            guard++;
        end
        cyc(100);
        chk("start_bit", int'(pin_d), 0);
        for (int k = 1; k <= 11; k++) begin
            dev_c = 1'b0;
            cyc(HP - 1);
            if (k <= 10) bits[k-1] = pin_d;
            cyc(1);
            dev_c = 1'b1;
            if (k == 10) dev_d = ack ? 1'b0 : 1'b1;
            if (glitch && k == 3) begin
                cyc(HP / 2);
                dev_c = 1'b0;
                cyc(10);
                dev_c = 1'b1;
                cyc(HP / 2 - 10);
            end else if (wr_mid && k == 5) begin
                cyc(HP / 2);
                wr = 1'b1;
                data = ~d;
                cyc(1);
                wr = 1'b0;
                data = 8'h00;
                cyc(HP / 2 - 1);
            end else begin
                cyc(HP);
            end
        end
        dev_d = 1'b1;
        guard = 0;
        while (busy && guard < 2000) begin
            @(negedge clk25);
            guard++;
        end
        cyc(20);
        dn = done_seen - d0;
        er = err_seen - e0;
    endtask

    typedef struct {
        logic [7:0] d;
        bit         ack;
        bit         glitch;
        bit         wr_mid;
        bit         par;
        int         dn;
        int         er;
    } vec_t;

    initial begin
        vec_t       vt[5];
        logic [9:0] bits;
        int         inh_n, set_n, dn, er, n, e0;

        vt[0] = '{8'hED, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0};
        vt[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0};
        vt[2] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1, 0};
        vt[3] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1};
        vt[4] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0};

        rst = 1'b1;
        wr = 1'b0;
        data = 8'h00;
        cyc(3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_c_oe", int'(ps2c_oe), 0);
        chk("rst_d_oe", int'(ps2d_oe), 0);
        rst = 1'b0;
        cyc(100);

        for (int i = 0; i < 5; i++) begin
            run_frame(vt[i].d, vt[i].ack, vt[i].glitch, vt[i].wr_mid, bits, inh_n, set_n, dn, er);
            chk("rx_byte", int'(bits[7:0]), int'(vt[i].d));
            chk("rx_parity", int'(bits[8]), int'(vt[i].par));
            chk("rx_stop", int'(bits[9]), 1);
            chk("inhibit_len", inh_n, INH);
            chk("setup_len", set_n, SET);
            chk("done_count", dn, vt[i].dn);
            chk("err_count", er, vt[i].er);
            chk("end_busy", int'(busy), 0);
            chk("end_c_oe", int'(ps2c_oe), 0);
            chk("end_d_oe", int'(ps2d_oe), 0);
        end

        // Device never clocks: err must follow clock release by exactly TO cycles.
        e0 = done_seen;
        @(negedge clk25);
        wr = 1'b1;
        data = 8'h55;
        @(negedge clk25);
        wr = 1'b0;
        n = 0;
        while (ps2c_oe && n < 5000) begin
            @(negedge clk25);
            n++;
        end
        chk("to_released", int'(ps2c_oe), 0);
        n = 0;
        while (!err && n < TO + 100) begin
            @(negedge clk25);
            n++;
        end
        chk("timeout_cycles", n, TO);
        chk("to_err", int'(err), 1);
        chk("to_busy", int'(busy), 0);
        chk("to_c_oe", int'(ps2c_oe), 0);
        chk("to_d_oe", int'(ps2d_oe), 0);
        cyc(5);
        chk("to_no_done", done_seen - e0, 0);

        run_frame(8'hFF, 1'b1, 1'b0, 1'b0, bits, inh_n, set_n, dn, er);
        chk("ff_byte", int'(bits[7:0]), 8'hFF);
        chk("ff_parity", int'(bits[8]), 1);
        chk("ff_done", dn, 1);
        chk("ff_err", er, 0);

        // Reset in the middle of SHIFT, after four bits have gone out.
        @(negedge clk25);
        wr = 1'b1;
        data = 8'h35;
        @(negedge clk25);
        wr = 1'b0;
        n = 0;
        while (ps2c_oe && n < 5000) begin
            @(negedge clk25);
            n++;
        end
        cyc(100);
        for (int k = 0; k < 4; k++) begin
            dev_c = 1'b0;
            cyc(HP);
            dev_c = 1'b1;
            cyc(HP);
        end
        chk("pre_rst_d_oe", int'(ps2d_oe), 1);
        chk("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk25);
        chk("mid_rst_c_oe", int'(ps2c_oe), 0);
        chk("mid_rst_d_oe", int'(ps2d_oe), 0);
        chk("mid_rst_busy", int'(busy), 0);
        rst = 1'b0;
        cyc(200);
        chk("post_rst_busy", int'(busy), 0);
        chk("done_err_overlap", both_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
